fifo64_sp: RTL and testbench
============================

// Module: fifo64_sp
// PURPOSE
//  64-deep single-clock FIFO whose storage is one distram64s (RAM64X1S, single shared address, async read).
//  Time-shares that one port between writes and read prefetch, and presents a show-ahead output register.
//  Used as the elastic buffer between aq32 bus-side producers and peripheral consumers (UART, SPI, audio).
// PARAMETERS
//  WIDTH  32  data width in bits, passed to distram64s.WIDTH.
// PORTS
//  clk        in   1      system clock; all state on rising edge
//  reset      in   1      asynchronous, active-high reset
//  flush      in   1      synchronous clear of all contents
//  wr_data    in   WIDTH  write data
//  wr_en      in   1      push request; ignored when full=1
//  full       out  1      1 when RAM holds 64 entries
//  rd_data    out  WIDTH  head of FIFO (output register), valid when rd_valid=1
//  rd_valid   out  1      output register holds data
//  rd_pop     in   1      consume rd_data; ignored when rd_valid=0
//  level      out  7      ram_count + rd_valid (0..65)
//  overflow   out  1      sticky: push attempted while full (see CONFIGURATION)
//  ovf_clr    in   1      clears overflow
// BEHAVIOUR
//  - Reset/flush: wr_ptr=rd_ptr=0, ram_count=0, rd_valid=0, rd_data=0, full=0, level=0, overflow=0 (flush leaves overflow).
//    Reset is async assert; flush wins over any push/pop in the same cycle.
//  - State: wr_ptr[5:0], rd_ptr[5:0], ram_count[6:0] (0..64), out register. Pointers wrap 63->0 naturally.
//  - push = wr_en & ~full. pop = rd_pop & rd_valid. out_free = ~rd_valid | pop.
//  - Port arbitration per cycle (write has priority):
//    * BYPASS: push & ram_count==0 & out_free -> wr_data loads output register next edge; RAM untouched.
//    * WRITE: push otherwise -> addr=wr_ptr, wren all-ones, wr_ptr++, ram_count++. No prefetch this cycle.
//    * PREFETCH: no push & ram_count!=0 & out_free -> addr=rd_ptr, rd_data<=rddata, rd_ptr++, ram_count--.
//    * else: addr=rd_ptr, no RAM write.
//  - rd_valid next = BYPASS | PREFETCH | (rd_valid & ~pop).
//  - Latency: push into empty FIFO -> rd_valid=1 the next cycle (1-cycle fall-through).
//  - Push+pop same cycle with ram_count>0: write wins, output not refilled, rd_valid=0 next cycle;
//    refill happens first cycle without push. Sustained push starves refill by design.
//  - full = (ram_count==64); a push while full is dropped, contents unchanged.
//  - level and full are registered-state derived (no comb path from wr_en/rd_pop).
// CONFIGURATION
//  FIFO64_SP_OVERFLOW_EN defined: overflow sets on wr_en & full, holds until ovf_clr (clr wins if same cycle).
//  Not defined: overflow tied 0, ovf_clr ignored, no extra flops.
// STRUCTURE
//  Shared package/include: FIFO64_DEPTH=64, FIFO64_AW=6, FIFO64_CW=7.
//  One sub-module: distram64s #(.WIDTH(WIDTH)) storage; wren = {WIDTH{ram_we}}.
//  All pointer/arbitration logic in fifo64_sp.
// TESTING
//  1 Reset mid-traffic (level=10) -> next cycle level=0, rd_valid=0, full=0, rd_data=0.
//  2 Push 0xA5 into empty -> next cycle rd_valid=1, rd_data=0xA5, level=1; pop -> rd_valid=0, level=0.
//  3 Push 65 values 0..64 with no pops -> rd_data=0, full=1 after 65th, level=65; 66th push dropped;
//    overflow=1 when macro defined, 0 otherwise.
//  4 Pop 65 entries -> strictly 0..64 in order, pointer wrap 63->0 exercised, level returns to 0.
//  5 ram_count=3, push+pop same cycle -> rd_valid=0 next cycle, refilled with old head+1 one cycle later.
//  6 flush with push+pop asserted at level=5 -> level=0, rd_valid=0; overflow unchanged; ovf_clr clears it.

Source files
------------

// File: rtl/fifo64_sp_pkg.sv
// Shared sizing constants for the 64-deep single-port FIFO and its storage.
package fifo64_sp_pkg;
  localparam int FIFO64_DEPTH = 64;
  localparam int FIFO64_AW    = 6;
  localparam int FIFO64_CW    = 7;
endpackage

// File: rtl/distram64s.sv
// 64 x WIDTH distributed RAM: one shared address, per-bit write enable, async read.
module distram64s
  import fifo64_sp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic [FIFO64_AW-1:0] addr,
  input  logic [WIDTH-1:0]     wren,
  input  logic [WIDTH-1:0]     wrdata,
  output logic [WIDTH-1:0]     rddata
);
  logic [WIDTH-1:0] mem [FIFO64_DEPTH];

  always_ff @(posedge clk) begin
    for (int i = 0; i < WIDTH; i++) begin
      if (wren[i]) mem[addr][i] <= wrdata[i];
    end
  end

  assign rddata = mem[addr];
endmodule

// File: rtl/fifo64_sp.sv
// Show-ahead 64-entry FIFO time-sharing one RAM port between writes and prefetch.
// Optional sticky overflow flag enabled by defining FIFO64_SP_OVERFLOW_EN.
module fifo64_sp
  import fifo64_sp_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 flush,
  input  logic [WIDTH-1:0]     wr_data,
  input  logic                 wr_en,
  output logic                 full,
  output logic [WIDTH-1:0]     rd_data,
  output logic                 rd_valid,
  input  logic                 rd_pop,
  output logic [FIFO64_CW-1:0] level,
  output logic                 overflow,
  input  logic                 ovf_clr
);
  logic [FIFO64_AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, ram_addr;
  logic [FIFO64_CW-1:0] ram_count_q, ram_count_d;
  logic [WIDTH-1:0]     rd_data_q, rd_data_d, ram_rdata;
  logic                 rd_valid_q, rd_valid_d;
  logic                 ram_we, push, pop, out_free, bypass, prefetch;

  assign full = (ram_count_q == FIFO64_CW'(FIFO64_DEPTH));

  always_comb begin
    push     = wr_en & ~full;
    pop      = rd_pop & rd_valid_q;
    out_free = ~rd_valid_q | pop;
    // Write owns the port whenever it needs it; bypass skips the RAM entirely.
    bypass   = push & (ram_count_q == '0) & out_free;
    prefetch = ~push & (ram_count_q != '0) & out_free;

    wr_ptr_d    = wr_ptr_q;
    rd_ptr_d    = rd_ptr_q;
    ram_count_d = ram_count_q;
    rd_data_d   = rd_data_q;
    rd_valid_d  = bypass | prefetch | (rd_valid_q & ~pop);
    ram_addr    = rd_ptr_q;
    ram_we      = 1'b0;

    if (push && !bypass) begin
      ram_addr    = wr_ptr_q;
      ram_we      = 1'b1;
      wr_ptr_d    = wr_ptr_q + 1'b1;
      ram_count_d = ram_count_q + 1'b1;
    end
    if (bypass) rd_data_d = wr_data;
    if (prefetch) begin
      rd_data_d   = ram_rdata;
      rd_ptr_d    = rd_ptr_q + 1'b1;
      ram_count_d = ram_count_q - 1'b1;
    end

    if (flush) begin
      wr_ptr_d    = '0;
      rd_ptr_d    = '0;
      ram_count_d = '0;
      rd_data_d   = '0;
      rd_valid_d  = 1'b0;
      ram_we      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      ram_count_q <= '0;
      rd_data_q   <= '0;
      rd_valid_q  <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      ram_count_q <= ram_count_d;
      rd_data_q   <= rd_data_d;
      rd_valid_q  <= rd_valid_d;
    end
  end

  distram64s #(.WIDTH(WIDTH)) u_storage (
    .clk    (clk),
    .addr   (ram_addr),
    .wren   ({WIDTH{ram_we}}),
    .wrdata (wr_data),
    .rddata (ram_rdata)
  );

  assign rd_data  = rd_data_q;
  assign rd_valid = rd_valid_q;
  assign level    = ram_count_q + {{(FIFO64_CW-1){1'b0}}, rd_valid_q};

`ifdef FIFO64_SP_OVERFLOW_EN
  logic overflow_q, overflow_d;

  // Clear beats a same-cycle set; flush deliberately leaves the flag alone.
  always_comb begin
    overflow_d = ovf_clr ? 1'b0 : (overflow_q | (wr_en & full));
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) overflow_q <= 1'b0;
    else       overflow_q <= overflow_d;
  end

  assign overflow = overflow_q;
`else
  logic unused_ovf_clr;
  assign unused_ovf_clr = ovf_clr;
  assign overflow       = 1'b0;
`endif
endmodule

// File: tb/tb_fifo64_sp.sv
// Directed bench for fifo64_sp: reset, fall-through, fill/drain with wrap, arbitration, flush.
module tb_fifo64_sp;
  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, flush, wr_en, rd_pop, ovf_clr;
  logic [W-1:0]  wr_data;
  logic          full, rd_valid, overflow;
  logic [W-1:0]  rd_data;
  logic [6:0]    level;
  int            checks = 0;
  int            failures = 0;

`ifdef FIFO64_SP_OVERFLOW_EN
  localparam logic EXP_OVF = 1'b1;
`else
  localparam logic EXP_OVF = 1'b0;
`endif

  fifo64_sp #(.WIDTH(W)) dut (
    .clk      (clk),
    .reset    (reset),
    .flush    (flush),
    .wr_data  (wr_data),
    .wr_en    (wr_en),
    .full     (full),
    .rd_data  (rd_data),
    .rd_valid (rd_valid),
    .rd_pop   (rd_pop),
    .level    (level),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1; flush = 1'b0; wr_en = 1'b0; rd_pop = 1'b0; ovf_clr = 1'b0; wr_data = '0;
    tick; tick;
    checks++;
    if (level !== 7'd0 || rd_valid !== 1'b0 || full !== 1'b0 || rd_data !== '0 || overflow !== 1'b0) begin
      failures++;
      $display("FAIL reset_init: level=%0d rd_valid=%b full=%b rd_data=%h ovf=%b expected 0/0/0/0/0",
               level, rd_valid, full, rd_data, overflow);
    end
    reset = 1'b0;
    tick;
    for (int i = 0; i < 10; i++) begin
      wr_en = 1'b1; wr_data = W'(32'h100 + i);
      tick;
    end
    wr_en = 1'b0;
    checks++;
    if (level !== 7'd10) begin
      failures++;
      $display("FAIL reset_pre_level: got %0d expected 10", level);
    end
    reset = 1'b1;
    tick;
    checks++;
    if (level !== 7'd0 || rd_valid !== 1'b0 || full !== 1'b0 || rd_data !== '0) begin
      failures++;
      $display("FAIL reset_mid: level=%0d rd_valid=%b full=%b rd_data=%h expected 0/0/0/0",
               level, rd_valid, full, rd_data);
    end
    reset = 1'b0;
    tick;
  endtask

  task automatic test_fall_through;
    wr_en = 1'b1; wr_data = 32'hA5;
    tick;
    wr_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'hA5 || level !== 7'd1) begin
      failures++;
      $display("FAIL fall_through: rd_valid=%b rd_data=%h level=%0d expected 1/a5/1", rd_valid, rd_data, level);
    end
    rd_pop = 1'b1;
    tick;
    rd_pop = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || level !== 7'd0) begin
      failures++;
      $display("FAIL fall_through_pop: rd_valid=%b level=%0d expected 0/0", rd_valid, level);
    end
  endtask

  task automatic test_push_pop_same_cycle;
    for (int i = 0; i < 4; i++) begin
      wr_en = 1'b1; wr_data = W'(10 + i);
      tick;
    end
    wr_en = 1'b0;
    checks++;
    if (level !== 7'd4 || rd_data !== 32'd10) begin
      failures++;
      $display("FAIL pp_setup: level=%0d rd_data=%0d expected 4/10", level, rd_data);
    end
    wr_en = 1'b1; wr_data = 32'd14; rd_pop = 1'b1;
    tick;
    wr_en = 1'b0; rd_pop = 1'b0;
    checks++;
    if (rd_valid !== 1'b0 || level !== 7'd4) begin
      failures++;
      $display("FAIL pp_starve: rd_valid=%b level=%0d expected 0/4", rd_valid, level);
    end
    tick;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'd11 || level !== 7'd4) begin
      failures++;
      $display("FAIL pp_refill: rd_valid=%b rd_data=%0d level=%0d expected 1/11/4", rd_valid, rd_data, level);
    end
    for (int v = 11; v <= 14; v++) begin
      checks++;
      if (rd_valid !== 1'b1 || rd_data !== W'(v)) begin
        failures++;
        $display("FAIL pp_drain: rd_valid=%b rd_data=%0d expected 1/%0d", rd_valid, rd_data, v);
      end
      rd_pop = 1'b1;
      tick;
    end
    rd_pop = 1'b0;
    checks++;
    if (level !== 7'd0 || rd_valid !== 1'b0) begin
      failures++;
      $display("FAIL pp_empty: level=%0d rd_valid=%b expected 0/0", level, rd_valid);
    end
  endtask

  task automatic test_fill;
    for (int v = 0; v < 64; v++) begin
      wr_en = 1'b1; wr_data = W'(v);
      tick;
    end
    checks++;
    if (full !== 1'b0 || level !== 7'd64) begin
      failures++;
      $display("FAIL fill_64: full=%b level=%0d expected 0/64", full, level);
    end
    wr_data = 32'd64;
    tick;
    checks++;
    if (full !== 1'b1 || level !== 7'd65 || rd_data !== 32'd0 || rd_valid !== 1'b1) begin
      failures++;
      $display("FAIL fill_65: full=%b level=%0d rd_data=%0d rd_valid=%b expected 1/65/0/1",
               full, level, rd_data, rd_valid);
    end
    wr_data = 32'd999;
    tick;
    wr_en = 1'b0;
    checks++;
    if (full !== 1'b1 || level !== 7'd65 || overflow !== EXP_OVF) begin
      failures++;
      $display("FAIL fill_drop: full=%b level=%0d overflow=%b expected 1/65/%b", full, level, overflow, EXP_OVF);
    end
  endtask

  task automatic test_drain;
    int exp_v = 0;
    int cyc   = 0;
    while (exp_v <= 64 && cyc < 200) begin
      if (rd_valid === 1'b1) begin
        checks++;
        if (rd_data !== W'(exp_v)) begin
          failures++;
          $display("FAIL drain_order: got %0d expected %0d", rd_data, exp_v);
        end
        exp_v++;
        rd_pop = 1'b1;
      end else begin
        rd_pop = 1'b0;
      end
      tick;
      cyc++;
    end
    rd_pop = 1'b0;
    checks++;
    if (exp_v != 65) begin
      failures++;
      $display("FAIL drain_timeout: popped %0d expected 65", exp_v);
    end
    checks++;
    if (level !== 7'd0 || rd_valid !== 1'b0 || full !== 1'b0) begin
      failures++;
      $display("FAIL drain_empty: level=%0d rd_valid=%b full=%b expected 0/0/0", level, rd_valid, full);
    end
  endtask

  task automatic test_flush;
    for (int i = 0; i < 5; i++) begin
      wr_en = 1'b1; wr_data = W'(32'h50 + i);
      tick;
    end
    wr_en = 1'b0;
    checks++;
    if (level !== 7'd5) begin
      failures++;
      $display("FAIL flush_setup: level=%0d expected 5", level);
    end
    flush = 1'b1; wr_en = 1'b1; rd_pop = 1'b1; wr_data = 32'h77;
    tick;
    flush = 1'b0; wr_en = 1'b0; rd_pop = 1'b0;
    checks++;
    if (level !== 7'd0 || rd_valid !== 1'b0 || rd_data !== '0 || overflow !== EXP_OVF) begin
      failures++;
      $display("FAIL flush: level=%0d rd_valid=%b rd_data=%h overflow=%b expected 0/0/0/%b",
               level, rd_valid, rd_data, overflow, EXP_OVF);
    end
    ovf_clr = 1'b1;
    tick;
    ovf_clr = 1'b0;
    checks++;
    if (overflow !== 1'b0) begin
      failures++;
      $display("FAIL ovf_clr: overflow=%b expected 0", overflow);
    end
    wr_en = 1'b1; wr_data = 32'h77;
    tick;
    wr_en = 1'b0;
    checks++;
    if (rd_valid !== 1'b1 || rd_data !== 32'h77 || level !== 7'd1) begin
      failures++;
      $display("FAIL post_flush: rd_valid=%b rd_data=%h level=%0d expected 1/77/1", rd_valid, rd_data, level);
    end
  endtask

  initial begin
    test_reset;
    test_fall_through;
    test_push_pop_same_cycle;
    test_fill;
    test_drain;
    test_flush;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
